pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/julia_pkg.sv | 33 +++
 rtl/pixel_fifo.sv | 68 ++++++
 rtl/pixel_writer.sv | 120 ++++++++++++
 tb/tb_pixel_writer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// julia_pkg: definitions shared by the pixel writer and its FIFO.
//   BYTE_LANES         - byte lanes in one SDRAM data word
//   FIFO_DEPTH_DEFAULT - default number of buffered pixel writes
//   state_t            - frame control states
//   lane_mask()        - byte enables for a pixel at a byte offset
//   crosses_word()     - pixel would spill past the end of its word
package julia_pkg;

   localparam int unsigned BYTE_LANES         = 4;
   localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ((1 << size) - 1) << offset, cut down to the lanes of one word.
   function automatic logic [BYTE_LANES-1:0] lane_mask(input logic [7:0] size,
                                                       input logic [1:0] offset);
      logic [7:0] m;
      m = (8'd1 << size) - 8'd1;
      m = m << offset;
      return m[BYTE_LANES-1:0];
   endfunction

   function automatic logic crosses_word(input logic [7:0] size, input logic [1:0] offset);
      logic [8:0] s;
      s = {7'd0, offset} + {1'b0, size};
      return s > 9'(BYTE_LANES);
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO with registered occupancy.
//   clk, n_rst        - clock, asynchronous active-low reset
//   i_clr             - synchronous flush (wins over push/pop)
//   i_push, i_wdata   - write side; ignored when full
//   i_pop, o_rdata    - read side; o_rdata is the head, valid when not empty
//   o_full, o_empty   - status derived from the registered count
//   o_count           - number of stored entries
module pixel_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage is not reset; the head is only meaningful while not empty.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_clr) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // DEPTH is a power of two, so pointers wrap by overflow.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: buffers addressed pixels and writes them to SDRAM over an
// Avalon-MM write master, one pixel per bus word, with byte-lane steering.
//   clk, n_rst                 - clock, asynchronous active-low reset
//   start                      - begin a frame (ignored while running)
//   total_pixels, pixel_size   - frame length and bytes per pixel, sampled on start
//   in_valid/in_address/in_color/in_ready - upstream pixel handshake
//   avm_*                      - SDRAM write master, driven from the FIFO head
//   done                       - frame complete
//   error                      - sticky: a pixel crossed a word boundary
module pixel_writer
   import julia_pkg::*;
#(
   parameter int unsigned PIXELBITS  = 4,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  start,
   input  logic [19:0]           total_pixels,
   input  logic [PIXELBITS-1:0]  pixel_size,
   input  logic                  in_valid,
   input  logic [31:0]           in_address,
   input  logic [31:0]           in_color,
   output logic                  in_ready,
   output logic                  avm_write,
   output logic [31:0]           avm_address,
   output logic [31:0]           avm_writedata,
   output logic [BYTE_LANES-1:0] avm_byteenable,
   input  logic                  avm_waitrequest,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [19:0]          r_total;
   logic [PIXELBITS-1:0] r_size;
   logic [19:0]          r_written;
   logic [19:0]          w_written_nxt;
   logic                 r_error;

   logic                 w_start_ok;
   logic                 w_push;
   logic                 w_pop;
   logic [63:0]          w_head;
   logic [31:0]          w_head_addr;
   logic [31:0]          w_head_color;
   logic                 w_full;
   logic                 w_empty;
   logic [CW-1:0]        w_count;

   assign w_start_ok    = start && (r_state != ST_RUN);
   assign in_ready      = (r_state == ST_RUN) && !w_full;
   assign w_push        = in_valid && in_ready;
   assign w_pop         = avm_write && !avm_waitrequest;
   assign w_written_nxt = r_written + {19'd0, w_pop};

   pixel_fifo #(
      .WIDTH (64),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_clr   (w_start_ok),
      .i_push  (w_push),
      .i_wdata ({in_address, in_color}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_head_addr  = w_head[63:32];
   assign w_head_color = w_head[31:0];

   // Head outputs are forced to zero while empty so reset leaves the bus quiet.
   assign avm_write      = (w_count != '0);
   assign avm_address    = w_empty ? 32'd0 : {w_head_addr[31:2], 2'b00};
   assign avm_writedata  = w_empty ? 32'd0 : (w_head_color << {w_head_addr[1:0], 3'b000});
   assign avm_byteenable = w_empty ? '0 : lane_mask(8'(r_size), w_head_addr[1:0]);

   assign done  = (r_state == ST_DONE);
   assign error = r_error;

   // Completion looks at the count including this cycle's pop, so done rises
   // the cycle after the final write is accepted.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_RUN;
         ST_RUN:           if (w_written_nxt == r_total) w_state_nxt = ST_DONE;
         default:          w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= ST_IDLE;
         r_total   <= '0;
         r_size    <= '0;
         r_written <= '0;
         r_error   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start_ok) begin
            r_total   <= total_pixels;
            r_size    <= pixel_size;
            r_written <= '0;
            r_error   <= 1'b0;
         end else begin
            if (w_pop) r_written <= w_written_nxt;
            if (w_push && crosses_word(8'(r_size), in_address[1:0])) r_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed self-checking bench for pixel_writer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pixel_writer;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start;
   logic [19:0] total_pixels;
   logic [3:0]  pixel_size;
   logic        in_valid;
   logic [31:0] in_address;
   logic [31:0] in_color;
   logic        in_ready;
   logic        avm_write;
   logic [31:0] avm_address;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest;
   logic        done;
   logic        error;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pixel_writer #(
      .PIXELBITS  (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk             (clk),
      .n_rst           (n_rst),
      .start           (start),
      .total_pixels    (total_pixels),
      .pixel_size      (pixel_size),
      .in_valid        (in_valid),
      .in_address      (in_address),
      .in_color        (in_color),
      .in_ready        (in_ready),
      .avm_write       (avm_write),
      .avm_address     (avm_address),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_waitrequest (avm_waitrequest),
      .done            (done),
      .error           (error)
   );

   // Called on a falling edge; returns on the next one with the block in RUN.
   task automatic do_start(input logic [19:0] tot, input logic [3:0] sz);
      start        = 1'b1;
      total_pixels = tot;
      pixel_size   = sz;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b1;
      #3 n_rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, avm_write, avm_address, avm_writedata, avm_byteenable, done, error} !== 72'd0) begin
         failures++;
         $display("FAIL reset_outputs got rdy=%b wr=%b a=%h d=%h be=%h done=%b err=%b want all 0",
                  in_ready, avm_write, avm_address, avm_writedata, avm_byteenable, done, error);
      end
      n_rst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_ready got %b want 0", in_ready);
      end
   endtask

   task automatic test_single();
      avm_waitrequest = 1'b0;
      do_start(20'd1, 4'd4);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL single_ready got %b want 1", in_ready);
      end
      in_valid   = 1'b1;
      in_address = 32'h0000_0100;
      in_color   = 32'hAABB_CCDD;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({avm_write, avm_address, avm_writedata, avm_byteenable, done} !==
          {1'b1, 32'h0000_0100, 32'hAABB_CCDD, 4'hF, 1'b0}) begin
         failures++;
         $display("FAIL single_write got wr=%b a=%h d=%h be=%h done=%b want 1 100 aabbccdd f 0",
                  avm_write, avm_address, avm_writedata, avm_byteenable, done);
      end
      @(negedge clk);
      checks++;
      if ({done, avm_write, error} !== 3'b100) begin
         failures++;
         $display("FAIL single_done got done=%b wr=%b err=%b want 1 0 0", done, avm_write, error);
      end
   endtask

   task automatic test_byte_lanes();
      do_start(20'd1, 4'd2);
      in_valid   = 1'b1;
      in_address = 32'h0000_0102;
      in_color   = 32'h0000_1234;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({avm_address, avm_writedata, avm_byteenable, error} !==
          {32'h0000_0100, 32'h1234_0000, 4'hC, 1'b0}) begin
         failures++;
         $display("FAIL lanes_write got a=%h d=%h be=%h err=%b want 100 12340000 c 0",
                  avm_address, avm_writedata, avm_byteenable, error);
      end
      @(negedge clk);
      checks++;
      if ({done, error} !== 2'b10) begin
         failures++;
         $display("FAIL lanes_done got done=%b err=%b want 1 0", done, error);
      end
   endtask

   task automatic test_misalign();
      do_start(20'd2, 4'd2);
      in_valid   = 1'b1;
      in_address = 32'h0000_0103;
      in_color   = 32'h0000_00AB;
      @(negedge clk);
      in_address = 32'h0000_0200;
      in_color   = 32'h0000_5566;
      checks++;
      if ({avm_address, avm_writedata, avm_byteenable, error} !==
          {32'h0000_0100, 32'hAB00_0000, 4'h8, 1'b1}) begin
         failures++;
         $display("FAIL misalign_write got a=%h d=%h be=%h err=%b want 100 ab000000 8 1",
                  avm_address, avm_writedata, avm_byteenable, error);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({avm_address, avm_writedata, avm_byteenable, error} !==
          {32'h0000_0200, 32'h0000_5566, 4'h3, 1'b1}) begin
         failures++;
         $display("FAIL misalign_second got a=%h d=%h be=%h err=%b want 200 5566 3 1",
                  avm_address, avm_writedata, avm_byteenable, error);
      end
      @(negedge clk);
      checks++;
      if ({done, error} !== 2'b11) begin
         failures++;
         $display("FAIL misalign_sticky got done=%b err=%b want 1 1", done, error);
      end
      // A new start clears error; with zero pixels the frame ends at once.
      do_start(20'd0, 4'd4);
      checks++;
      if ({done, error} !== 2'b00) begin
         failures++;
         $display("FAIL restart_clear got done=%b err=%b want 0 0", done, error);
      end
      @(negedge clk);
      checks++;
      if ({done, avm_write} !== 2'b10) begin
         failures++;
         $display("FAIL zero_frame got done=%b wr=%b want 1 0", done, avm_write);
      end
   endtask

   task automatic test_backpressure();
      int  k;
      int  w;
      logic go;
      k = 0;
      w = 0;
      avm_waitrequest = 1'b1;
      do_start(20'd8, 4'd4);
      for (int c = 0; c < 10; c++) begin
         in_valid   = 1'b1;
         in_address = 32'h0000_1000 + 32'(4 * k);
         in_color   = 32'hC0DE_0000 + 32'(k);
         go = in_ready;
         @(negedge clk);
         if (go) k++;
      end
      checks++;
      if (k !== 4) begin
         failures++;
         $display("FAIL bp_accepted got %0d want 4", k);
      end
      checks++;
      if ({in_ready, avm_write, avm_address, avm_writedata} !==
          {1'b0, 1'b1, 32'h0000_1000, 32'hC0DE_0000}) begin
         failures++;
         $display("FAIL bp_hold got rdy=%b wr=%b a=%h d=%h want 0 1 1000 c0de0000",
                  in_ready, avm_write, avm_address, avm_writedata);
      end
      avm_waitrequest = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (avm_write) begin
            checks++;
            if ({avm_address, avm_writedata} !==
                {32'h0000_1000 + 32'(4 * w), 32'hC0DE_0000 + 32'(w)}) begin
               failures++;
               $display("FAIL bp_write%0d got a=%h d=%h want %h %h", w, avm_address,
                        avm_writedata, 32'h0000_1000 + 32'(4 * w), 32'hC0DE_0000 + 32'(w));
            end
            w++;
         end
         in_valid   = (k < 8);
         in_address = 32'h0000_1000 + 32'(4 * k);
         in_color   = 32'hC0DE_0000 + 32'(k);
         go = in_valid && in_ready;
         @(negedge clk);
         if (go) k++;
      end
      in_valid = 1'b0;
      checks++;
      if ({done, avm_write} !== 2'b10 || w !== 8) begin
         failures++;
         $display("FAIL bp_complete got done=%b wr=%b writes=%0d want 1 0 8", done, avm_write, w);
      end
   endtask

   task automatic test_reset_midframe();
      int extra;
      extra = 0;
      avm_waitrequest = 1'b1;
      do_start(20'd8, 4'd4);
      for (int i = 0; i < 3; i++) begin
         in_valid   = 1'b1;
         in_address = 32'h0000_2000 + 32'(4 * i);
         in_color   = 32'h0000_0050 + 32'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if ({avm_write, avm_address} !== {1'b1, 32'h0000_2000}) begin
         failures++;
         $display("FAIL mid_buffered got wr=%b a=%h want 1 2000", avm_write, avm_address);
      end
      n_rst = 1'b0;
      #1;
      checks++;
      if ({in_ready, avm_write, avm_address, avm_writedata, avm_byteenable, done, error} !== 72'd0) begin
         failures++;
         $display("FAIL mid_reset got rdy=%b wr=%b a=%h d=%h be=%h done=%b err=%b want all 0",
                  in_ready, avm_write, avm_address, avm_writedata, avm_byteenable, done, error);
      end
      @(negedge clk);
      n_rst = 1'b1;
      avm_waitrequest = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (avm_write || in_ready || done) extra++;
      end
      checks++;
      if (extra !== 0) begin
         failures++;
         $display("FAIL mid_no_reissue got %0d busy cycles want 0", extra);
      end
      do_start(20'd0, 4'd4);
      @(negedge clk);
      checks++;
      if ({done, avm_write} !== 2'b10) begin
         failures++;
         $display("FAIL mid_zero_frame got done=%b wr=%b want 1 0", done, avm_write);
      end
   endtask

   initial begin
      start           = 1'b0;
      total_pixels    = '0;
      pixel_size      = '0;
      in_valid        = 1'b0;
      in_address      = '0;
      in_color        = '0;
      avm_waitrequest = 1'b0;
      test_reset();
      test_single();
      test_byte_lanes();
      test_misalign();
      test_backpressure();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
